// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter for a shared single-port RAM with bounded CPU wait
//
// Purpose:
//   Shares one single-port data RAM (1-cycle read latency) between the VGA
//   framebuffer fetch unit (m0, read-only, fixed priority) and the CPU
//   load/store port (m1). A wait counter bounds how long an un-halted,
//   requesting CPU can be refused. halt freezes new CPU grants while VGA
//   refresh keeps running.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   halt                  1 = no new m1 grants
//   m0_req/m0_addr        VGA read request, held until m0_gnt
//   m0_gnt                combinational accept for m0
//   m0_rvalid/m0_rdata    VGA read return, one cycle after m0_gnt
//   m1_req/m1_we/m1_wstrb/m1_addr/m1_wdata
//                         CPU request, held until m1_gnt
//   m1_gnt                combinational accept for m1
//   m1_rvalid/m1_rdata    CPU read return, one cycle after a read m1_gnt
//   mem_en/mem_we/mem_wstrb/mem_addr/mem_wdata
//                         RAM command, driven from the granted master
//   mem_rdata             RAM read data, valid the cycle after a read
module mem_bus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                halt,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  // MAX_WAIT=0 would give a zero-width counter; keep one bit that simply stays 0.
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2
  } rd_owner_t;

  rd_owner_t        rd_owner;
  logic [CNT_W-1:0] wait_cnt;
  logic             cpu_ok;
  logic             force1;
  logic             gnt0;
  logic             gnt1;
  logic             m0_rvalid_q;
  logic             m1_rvalid_q;

  // ------------------------------------------------------------------
  // Grant decision (combinational). rst_n gates cpu_ok and gnt0 so that
  // nothing is granted, and the RAM is idle, while reset is held.
  // ------------------------------------------------------------------
  assign cpu_ok = rst_n & m1_req & ~halt;
  assign force1 = (wait_cnt == WAIT_LIMIT);
  assign gnt1   = cpu_ok & (~m0_req | force1);
  assign gnt0   = rst_n & m0_req & ~gnt1;

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // ------------------------------------------------------------------
  // RAM command mux. An m0 grant is always a read; with no grant every
  // command field is zero so the bus is quiet.
  // ------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt1) begin
      mem_en    = 1'b1;
      mem_we    = m1_we;
      mem_wstrb = m1_wstrb;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else if (gnt0) begin
      mem_en    = 1'b1;
      mem_addr  = m0_addr;
    end
  end

  // ------------------------------------------------------------------
  // Bounded-wait counter: counts consecutive cycles an eligible CPU is
  // refused. Any cycle the CPU is not eligible (idle or halted) clears it,
  // so halt never lets a stale count force a grant later.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (gnt1 || !cpu_ok) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // Read-return owner. The state of the next cycle depends only on this
  // cycle's grant, which is what makes back-to-back reads return data on
  // consecutive cycles. Writes leave the owner IDLE: they finish in their
  // grant cycle.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_owner    <= IDLE;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      if (gnt0) begin
        rd_owner    <= RD0;
        m0_rvalid_q <= 1'b1;
        m1_rvalid_q <= 1'b0;
      end else if (gnt1 && !m1_we) begin
        rd_owner    <= RD1;
        m0_rvalid_q <= 1'b0;
        m1_rvalid_q <= 1'b1;
      end else begin
        rd_owner    <= IDLE;
        m0_rvalid_q <= 1'b0;
        m1_rvalid_q <= 1'b0;
      end
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;

  // The RAM data port is shared, so the non-owning master sees zeros.
  assign m0_rdata = m0_rvalid_q ? mem_rdata : {DATA_W{1'b0}};
  assign m1_rdata = m1_rvalid_q ? mem_rdata : {DATA_W{1'b0}};

  // Strobe width is tied to the data width; referenced so a mismatched
  // DATA_W (not a multiple of 8) is visible at elaboration.
  localparam int STRB_BITS = STRB_W * 8;
  if (STRB_BITS != DATA_W) begin : g_bad_data_w
    localparam int DATA_W_NOT_BYTE_MULTIPLE = 1 / 0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n, halt;
  logic        m0_req;
  logic [15:0] m0_addr;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we;
  logic [3:0]  m1_wstrb;
  logic [15:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_wstrb;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port RAM with one cycle of read latency, cleared on the first edge.
  logic [31:0] ram [0:4095];
  logic        ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) ram[mem_addr[11:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[11:0]];
      end
    end
  end

  // Reference model: memory contents, consecutive-refusal count, and which
  // master (if any) is owed read data next cycle.
  logic [31:0] exp_mem [0:4095];
  int          refused = 0;
  int          owner = 0;      // 0 none, 1 VGA, 2 CPU
  logic [31:0] pend = '0;
  bit          model_ok = 0;
  bit          last_g0 = 0, last_g1 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic decide(output bit g0, output bit g1);
    bit eligible;
    eligible = rst_n && m1_req && !halt;
    g1 = eligible && (!m0_req || refused >= MAX_WAIT);
    g0 = rst_n && m0_req && !g1;
  endtask

  task automatic sample();
    bit g0, g1;
    @(negedge clk);
    decide(g0, g1);
    check("m0_gnt", m0_gnt, g0);
    check("m1_gnt", m1_gnt, g1);
    check("mem_en", mem_en, g0 | g1);
    check("mem_we", mem_we, g1 & m1_we);
    check("mem_wstrb", mem_wstrb, g1 ? m1_wstrb : 4'h0);
    check("mem_addr", mem_addr, g0 ? m0_addr : (g1 ? m1_addr : 16'h0));
    if (!g0) check("mem_wdata", mem_wdata, g1 ? m1_wdata : 32'h0);
    if (model_ok) begin
      check("m0_rvalid", m0_rvalid, owner == 1);
      check("m1_rvalid", m1_rvalid, owner == 2);
      check("m0_rdata", m0_rdata, (owner == 1) ? pend : 32'h0);
      check("m1_rdata", m1_rdata, (owner == 2) ? pend : 32'h0);
    end
  endtask

  task automatic tick();
    bit g0, g1, eligible;
    @(posedge clk);
    decide(g0, g1);
    eligible = rst_n && m1_req && !halt;
    if (!rst_n) begin
      refused = 0;
      owner = 0;
    end else begin
      owner = g0 ? 1 : ((g1 && !m1_we) ? 2 : 0);
      if (g0) pend = exp_mem[m0_addr[11:0]];
      else if (g1 && !m1_we) pend = exp_mem[m1_addr[11:0]];
      if (g1 && m1_we)
        for (int b = 0; b < 4; b++)
          if (m1_wstrb[b]) exp_mem[m1_addr[11:0]][8*b +: 8] = m1_wdata[8*b +: 8];
      refused = (!eligible || g1) ? 0 : refused + 1;
    end
    last_g0 = g0;
    last_g1 = g1;
    model_ok = 1;
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m1_req = 0; halt = 0;
    sample(); tick();
  endtask

  typedef struct {
    bit rst_n, halt, m0_req, m1_req, m1_we;
    bit e0, e1, een, ewe;
  } vec_t;
  vec_t vecs[8];

  initial begin
    for (int i = 0; i < 4096; i++) exp_mem[i] = '0;
    //              rst halt r0 r1 we | g0 g1 en we
    vecs[0] = '{1, 0, 0, 0, 0,  0, 0, 0, 0};
    vecs[1] = '{1, 0, 1, 0, 0,  1, 0, 1, 0};
    vecs[2] = '{1, 0, 0, 1, 0,  0, 1, 1, 0};
    vecs[3] = '{1, 0, 1, 1, 0,  1, 0, 1, 0};
    vecs[4] = '{1, 1, 0, 1, 0,  0, 0, 0, 0};
    vecs[5] = '{1, 1, 1, 1, 1,  1, 0, 1, 0};
    vecs[6] = '{0, 0, 1, 1, 0,  0, 0, 0, 0};
    vecs[7] = '{1, 0, 0, 1, 1,  0, 1, 1, 1};

    rst_n = 0; halt = 0;
    m0_req = 1; m0_addr = 16'h0300;
    m1_req = 1; m1_we = 0; m1_wstrb = 4'h0; m1_addr = 16'h0310; m1_wdata = '0;

    // Reset held for three clocks with both requests high.
    for (int i = 0; i < 3; i++) begin
      sample();
      check("rst_m0_gnt", m0_gnt, 0);
      check("rst_m1_gnt", m1_gnt, 0);
      check("rst_mem_en", mem_en, 0);
      if (i > 0) begin
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
      end
      tick();
    end
    rst_n = 1;
    sample();
    check("post_rst_m0_gnt", m0_gnt, 1);
    tick();

    // Solo CPU write then read back.
    m0_req = 0;
    m1_req = 1; m1_we = 1; m1_wstrb = 4'hF; m1_addr = 16'h0010; m1_wdata = 32'hDEADBEEF;
    sample(); check("solo_wr_gnt", m1_gnt, 1); tick();
    m1_we = 0; m1_wstrb = 4'h0;
    sample(); check("solo_rd_gnt", m1_gnt, 1); tick();
    m1_req = 0;
    sample();
    check("solo_rd_rvalid", m1_rvalid, 1);
    check("solo_rd_rdata", m1_rdata, 32'hDEADBEEF);
    tick();

    // Combinational grant table, each entry from a cleared wait count.
    for (int i = 0; i < 8; i++) begin
      idle();
      rst_n = vecs[i].rst_n; halt = vecs[i].halt;
      m0_req = vecs[i].m0_req; m0_addr = 16'h0040 + 16'(i);
      m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we; m1_addr = 16'h0060 + 16'(i);
      m1_wstrb = 4'h3; m1_wdata = 32'h1000 + 32'(i);
      sample();
      check($sformatf("vec%0d_m0_gnt", i), m0_gnt, vecs[i].e0);
      check($sformatf("vec%0d_m1_gnt", i), m1_gnt, vecs[i].e1);
      check($sformatf("vec%0d_mem_en", i), mem_en, vecs[i].een);
      check($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].ewe);
      tick();
      rst_n = 1;
    end
    idle();

    // Starvation bound: with VGA always requesting, the CPU wins every 5th cycle.
    m0_req = 1; m0_addr = 16'h0200;
    m1_req = 1; m1_we = 0; m1_addr = 16'h0210;
    for (int i = 0; i < 15; i++) begin
      sample();
      check($sformatf("starve%0d_m1_gnt", i), m1_gnt, (i % 5) == 4);
      check($sformatf("starve%0d_m0_gnt", i), m0_gnt, (i % 5) != 4);
      tick();
    end
    idle();

    // Pipelined VGA reads of 0x0100..0x0103 after CPU fills them.
    m1_req = 1; m1_we = 1; m1_wstrb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      m1_addr = 16'h0100 + 16'(k); m1_wdata = 32'hA0A00000 + 32'(k);
      sample(); check("fill_gnt", m1_gnt, 1); tick();
    end
    m1_req = 0;
    for (int k = 0; k < 5; k++) begin
      m0_req = (k < 4); m0_addr = 16'h0100 + 16'(k);
      sample();
      if (k < 4) check($sformatf("pipe%0d_m0_gnt", k), m0_gnt, 1);
      if (k > 0) begin
        check($sformatf("pipe%0d_rvalid", k), m0_rvalid, 1);
        check($sformatf("pipe%0d_rdata", k), m0_rdata, 32'hA0A00000 + 32'(k - 1));
      end
      tick();
    end
    idle();

    // Halt with a pending CPU read, then release.
    m1_req = 1; m1_we = 0; m1_addr = 16'h0010; halt = 1;
    for (int i = 0; i < 10; i++) begin
      sample();
      check("halt_m1_gnt", m1_gnt, 0);
      check("halt_mem_en", mem_en, 0);
      check("halt_wait_cnt", dut.wait_cnt, 0);
      tick();
    end
    halt = 0;
    sample(); check("unhalt_m1_gnt", m1_gnt, 1); tick();
    halt = 1;   // read granted just before halt rises still returns
    sample();
    check("halt_late_rvalid", m1_rvalid, 1);
    check("halt_late_rdata", m1_rdata, 32'hDEADBEEF);
    tick();
    idle();

    // Reset landing on the edge that would register a CPU read.
    m1_req = 1; m1_we = 0; m1_addr = 16'h0010;
    sample(); check("rstA_gnt", m1_gnt, 1);
    rst_n = 0; tick();
    rst_n = 1; m1_req = 0;
    sample(); check("rstA_m1_rvalid", m1_rvalid, 0); check("rstA_m1_rdata", m1_rdata, 0); tick();

    // Reset in the cycle after a read grant drops the next return.
    m1_req = 1;
    sample(); tick();
    m1_req = 0; rst_n = 0;
    sample(); tick();
    rst_n = 1;
    sample(); check("rstB_m1_rvalid", m1_rvalid, 0); check("rstB_m0_rvalid", m0_rvalid, 0); tick();

    // Randomized traffic honouring the hold-until-grant protocol.
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 99) < 15) halt = ~halt;
      if (!(m0_req && !last_g0)) begin
        m0_req = ($urandom_range(0, 99) < 55);
        m0_addr = 16'h0020 + 16'($urandom_range(0, 15));
      end
      if (!(m1_req && !last_g1)) begin
        m1_req = ($urandom_range(0, 99) < 60);
        m1_we = $urandom_range(0, 1);
        m1_wstrb = 4'($urandom_range(0, 15));
        m1_addr = 16'h0020 + 16'($urandom_range(0, 15));
        m1_wdata = $urandom;
      end
      sample();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
